// File: rtl/fsm_cmd_pkg.sv
// Shared types and constants for the command sanitizer that feeds the 3-bit
// control FSM's data_input.
package fsm_cmd_pkg;

  typedef logic [2:0] cmd_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GAP    = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam cmd_t SAFE_CMD      = 3'h0;
  localparam cmd_t CMD_MAX_LEGAL = 3'h5;

  function automatic logic is_legal(cmd_t c);
    return (c <= CMD_MAX_LEGAL);
  endfunction

endpackage

// File: rtl/fsm_cmd_sanitizer_if.sv
// Bundle of the user-side command handshake and the sanitized FSM-side outputs.
// Handshake: a command transfers on a rising clk edge where in_valid && in_ready.
// in_valid may rise at any time. in_cmd must be held stable while in_valid is
// high and in_ready is low. in_ready does not depend on in_valid.
interface fsm_cmd_sanitizer_if #(
  parameter int CNT_W = 8
);
  import fsm_cmd_pkg::*;

  logic             in_valid;
  logic             in_ready;
  cmd_t             in_cmd;
  cmd_t             cmd_out;
  logic             cmd_strobe;
  logic             illegal_pulse;
  logic [CNT_W-1:0] illegal_cnt;
  logic             locked;
  logic             clear_lock;

  modport master (
    output in_valid, in_cmd, clear_lock,
    input  in_ready, cmd_out, cmd_strobe, illegal_pulse, illegal_cnt, locked
  );

  modport slave (
    input  in_valid, in_cmd, clear_lock,
    output in_ready, cmd_out, cmd_strobe, illegal_pulse, illegal_cnt, locked
  );

endinterface

// File: rtl/fsm_cmd_sanitizer_cmd_fifo.sv
// Synchronous FIFO with extra-MSB pointers. Flush returns both pointers to zero
// and takes priority over a push or pop in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fsm_cmd_sanitizer.sv
// Issues queued user commands one at a time to the control FSM. Illegal codes
// are replaced by SAFE_CMD and counted, and enough of them lock the output.
module fsm_cmd_sanitizer
  import fsm_cmd_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int GAP         = 1,
  parameter int LOCK_THRESH = 4,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fsm_cmd_sanitizer_if.slave   bus,
  output state_t               state_dbg
);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_t           state_q, state_n;
  logic [GW-1:0]    gcnt_q, gcnt_n;
  cmd_t             cmd_q, cmd_n;
  logic             strobe_q, strobe_n;
  logic             pulse_q, pulse_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [CNT_W-1:0] cnt_inc;

  cmd_t head;
  logic full, empty, pop, flush, push, head_legal;

  // While locked every offered command is taken and thrown away.
  assign bus.in_ready = (state_q == S_LOCKED) || !full;
  assign push         = bus.in_valid && bus.in_ready && (state_q != S_LOCKED);

  cmd_fifo #(.DEPTH(DEPTH), .W(3)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (bus.in_cmd),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n    = state_q;
    gcnt_n     = gcnt_q;
    cmd_n      = cmd_q;
    strobe_n   = 1'b0;
    pulse_n    = 1'b0;
    cnt_n      = cnt_q;
    pop        = 1'b0;
    flush      = 1'b0;
    head_legal = is_legal(head);
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          strobe_n = 1'b1;
          cmd_n    = head_legal ? head : SAFE_CMD;
          state_n  = (GAP > 0) ? S_GAP : S_IDLE;
          gcnt_n   = GW'(GAP);
          if (!head_legal) begin
            pulse_n = 1'b1;
            cnt_n   = cnt_inc;
            // A clear arriving with the threshold-reaching issue cancels the lock.
            if (!bus.clear_lock && (cnt_inc >= CNT_W'(LOCK_THRESH))) begin
              state_n = S_LOCKED;
              flush   = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        if (gcnt_q <= GW'(1)) state_n = S_IDLE;
        else                  gcnt_n  = gcnt_q - GW'(1);
      end
      S_LOCKED: begin
        flush = 1'b1;
        cmd_n = SAFE_CMD;
        if (bus.clear_lock) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (bus.clear_lock) cnt_n = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gcnt_q   <= '0;
      cmd_q    <= SAFE_CMD;
      strobe_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_n;
      gcnt_q   <= gcnt_n;
      cmd_q    <= cmd_n;
      strobe_q <= strobe_n;
      pulse_q  <= pulse_n;
      cnt_q    <= cnt_n;
    end
  end

  assign bus.cmd_out       = cmd_q;
  assign bus.cmd_strobe    = strobe_q;
  assign bus.illegal_pulse = pulse_q;
  assign bus.illegal_cnt   = cnt_q;
  assign bus.locked        = (state_q == S_LOCKED);
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_fsm_cmd_sanitizer.sv
// Directed bench for fsm_cmd_sanitizer (DEPTH=4, GAP=1, LOCK_THRESH=4, CNT_W=8).
module tb_fsm_cmd_sanitizer;
  import fsm_cmd_pkg::*;

  logic   clk;
  logic   rst;
  state_t state_dbg;
  int     total = 0;
  int     bad   = 0;

  logic [2:0] exp_q[$];

  fsm_cmd_sanitizer_if #(.CNT_W(8)) bus ();

  fsm_cmd_sanitizer #(
    .DEPTH(4), .GAP(1), .LOCK_THRESH(4), .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [2:0] c);
    bus.in_valid = 1'b1;
    bus.in_cmd   = c;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    step();
    while (bus.cmd_strobe !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.cmd_strobe), 1);
  endtask

  task automatic pulse_clear();
    bus.clear_lock = 1'b1;
    step();
    bus.clear_lock = 1'b0;
  endtask

  logic [2:0] pat [4];
  int         sent, got, guard, strobes;
  logic       saw_full, acc;

  initial begin
    pat = '{3'h1, 3'h2, 3'h3, 3'h5};
    bus.in_valid   = 1'b0;
    bus.in_cmd     = 3'h0;
    bus.clear_lock = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("rst_cmd_out", 32'(bus.cmd_out), 0);
    chk("rst_strobe", 32'(bus.cmd_strobe), 0);
    chk("rst_pulse", 32'(bus.illegal_pulse), 0);
    chk("rst_cnt", 32'(bus.illegal_cnt), 0);
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    rst = 1'b0;
    step();

    // latency and GAP spacing
    push(3'h4);
    chk("lat_no_strobe_e0", 32'(bus.cmd_strobe), 0);
    step();
    chk("lat_strobe_e1", 32'(bus.cmd_strobe), 1);
    chk("lat_cmd_e1", 32'(bus.cmd_out), 4);
    step();
    chk("lat_strobe_off", 32'(bus.cmd_strobe), 0);
    bus.in_valid = 1'b1;
    bus.in_cmd   = 3'h1;
    step();
    bus.in_cmd   = 3'h2;
    step();
    bus.in_valid = 1'b0;
    chk("gap_first_strobe", 32'(bus.cmd_strobe), 1);
    chk("gap_first_cmd", 32'(bus.cmd_out), 1);
    step();
    chk("gap_idle_strobe", 32'(bus.cmd_strobe), 0);
    chk("gap_hold_cmd", 32'(bus.cmd_out), 1);
    step();
    chk("gap_second_strobe", 32'(bus.cmd_strobe), 1);
    chk("gap_second_cmd", 32'(bus.cmd_out), 2);
    step();

    // single illegal command
    push(3'h7);
    wait_strobe("ill_strobe");
    chk("ill_cmd_safe", 32'(bus.cmd_out), 0);
    chk("ill_pulse", 32'(bus.illegal_pulse), 1);
    chk("ill_cnt", 32'(bus.illegal_cnt), 1);
    chk("ill_locked", 32'(bus.locked), 0);
    step();
    chk("ill_pulse_off", 32'(bus.illegal_pulse), 0);
    pulse_clear();
    chk("clr_cnt", 32'(bus.illegal_cnt), 0);

    // lock after four illegal issues
    for (int k = 1; k <= 4; k++) begin
      push(3'h6);
      wait_strobe("lock_strobe");
      chk("lock_cnt", 32'(bus.illegal_cnt), 32'(k));
      chk("lock_locked", 32'(bus.locked), (k == 4) ? 1 : 0);
      chk("lock_cmd_safe", 32'(bus.cmd_out), 0);
    end
    chk("lock_state", 32'(state_dbg), 32'(S_LOCKED));
    chk("lock_ready", 32'(bus.in_ready), 1);
    push(3'h2);
    for (int k = 0; k < 3; k++) begin
      chk("lock_no_strobe", 32'(bus.cmd_strobe), 0);
      chk("lock_cmd_held", 32'(bus.cmd_out), 0);
      step();
    end
    chk("lock_still", 32'(bus.locked), 1);
    pulse_clear();
    chk("unlock_locked", 32'(bus.locked), 0);
    chk("unlock_cnt", 32'(bus.illegal_cnt), 0);
    chk("unlock_state", 32'(state_dbg), 32'(S_IDLE));
    strobes = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.cmd_strobe === 1'b1) strobes++;
    end
    chk("unlock_flushed", 32'(strobes), 0);

    // fill, backpressure and in-order drain over three fills (scoreboard)
    sent = 0; got = 0; guard = 0; saw_full = 1'b0;
    while ((sent < 12 || exp_q.size() > 0) && guard < 300) begin
      if (sent < 12) begin
        bus.in_valid = 1'b1;
        bus.in_cmd   = pat[sent % 4];
      end else begin
        bus.in_valid = 1'b0;
      end
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) begin
        exp_q.push_back(bus.in_cmd);
        sent++;
      end
      if (bus.in_ready === 1'b0) saw_full = 1'b1;
      if (bus.cmd_strobe === 1'b1) begin
        if (exp_q.size() == 0) chk("drain_unexpected", 32'(bus.cmd_strobe), 0);
        else begin
          chk("drain_order", 32'(bus.cmd_out), 32'(exp_q.pop_front()));
          got++;
        end
      end
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("drain_timeout", 32'(exp_q.size()), 0);
    chk("drain_count", 32'(got), 12);
    chk("fifo_full_seen", 32'(saw_full), 1);
    step();

    // clear coinciding with the threshold-reaching illegal issue
    for (int k = 1; k <= 3; k++) begin
      push(3'h7);
      wait_strobe("race_strobe");
      chk("race_cnt", 32'(bus.illegal_cnt), 32'(k));
    end
    step();
    push(3'h7);
    bus.clear_lock = 1'b1;
    step();
    bus.clear_lock = 1'b0;
    chk("race_issue_strobe", 32'(bus.cmd_strobe), 1);
    chk("race_issue_pulse", 32'(bus.illegal_pulse), 1);
    chk("race_locked", 32'(bus.locked), 0);
    chk("race_cnt_zero", 32'(bus.illegal_cnt), 0);
    step();
    chk("race_locked_after", 32'(bus.locked), 0);
    chk("race_state", 32'(state_dbg), 32'(S_IDLE));

    // reset with three entries queued mid-GAP
    push(3'h1); push(3'h7); push(3'h3); push(3'h4); push(3'h5); push(3'h1);
    chk("pre_rst_state", 32'(state_dbg), 32'(S_GAP));
    chk("pre_rst_cmd", 32'(bus.cmd_out), 3);
    chk("pre_rst_cnt", 32'(bus.illegal_cnt), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cmd", 32'(bus.cmd_out), 0);
    chk("mid_rst_strobe", 32'(bus.cmd_strobe), 0);
    chk("mid_rst_cnt", 32'(bus.illegal_cnt), 0);
    chk("mid_rst_locked", 32'(bus.locked), 0);
    chk("mid_rst_ready", 32'(bus.in_ready), 1);
    chk("mid_rst_state", 32'(state_dbg), 32'(S_IDLE));
    step();
    rst = 1'b0;
    strobes = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.cmd_strobe === 1'b1) strobes++;
    end
    chk("post_rst_no_strobe", 32'(strobes), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_cmd_sanitizer.md
# fsm_cmd_sanitizer

Upstream front-end for the 3-bit command-driven control FSM. It accepts user commands over a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time on a registered `cmd_out` bus that connects directly to the FSM's `data_input`. Illegal encodings (3'h6, 3'h7) never reach the FSM: they are replaced by a safe code, counted, and after a threshold the block locks the FSM input to the safe code until software clears it.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, at least 2
- `GAP`, 1, idle cycles enforced after each issued command (0 = back-to-back)
- `LOCK_THRESH`, 4, illegal-command count that triggers lock (1..2^CNT_W-1)
- `CNT_W`, 8, width of the illegal-command counter
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  command present on `in_cmd`
- `in_ready`  out  1  block can accept; `in_ready = !fifo_full` in ACTIVE states, 1 in LOCKED
- `in_cmd`  in  3  raw user command
- `cmd_out`  out  3  registered sanitized command to the FSM's `data_input`
- `cmd_strobe`  out  1  one-cycle pulse: `cmd_out` updated this cycle
- `illegal_pulse`  out  1  one-cycle pulse coincident with `cmd_strobe` when the issued command was illegal
- `illegal_cnt`  out  CNT_W  saturating count of illegal commands since reset or clear
- `locked`  out  1  lock status
- `clear_lock`  in  1  single-cycle request: clear counter and leave LOCKED

## Operation
- Legal codes are 3'h0..3'h5. Codes 3'h6 and 3'h7 are illegal. The safe code `SAFE_CMD` is 3'h0.
- Push: when `in_valid && in_ready`, `in_cmd` is written to the FIFO.
  - In LOCKED, the accepted command is discarded instead.
- The FSM has three states: IDLE, GAP, LOCKED.
- IDLE:
  - If the FIFO is non-empty, pop the head.
  - `cmd_out` <= head if legal, else `SAFE_CMD`.
  - Pulse `cmd_strobe`.
  - Next state is GAP if `GAP>0`, else IDLE.
- GAP: no pops. A down-counter loaded with `GAP` returns the block to IDLE when it reaches 0.
- Illegal issue:
  - Pulse `illegal_pulse`.
  - `illegal_cnt` increments, saturating at all-ones.
  - If the incremented value is at least `LOCK_THRESH`, next state is LOCKED and `locked` is set on the same edge; the GAP state is skipped.
- LOCKED:
  - FIFO is flushed (pointers reset) on entry.
  - `cmd_out` is held at `SAFE_CMD`; no strobes are issued.
  - Inputs are accepted and dropped.
- `clear_lock`:
  - Clears `illegal_cnt` in any state.
  - In LOCKED, the block goes to IDLE and `locked` falls on the same edge.
  - If `clear_lock` coincides with an illegal issue, the clear wins: count becomes 0 and there is no lock.
- Simultaneous push and pop on a non-full FIFO: both occur and occupancy is unchanged.
  - A push is never accepted when full, even if a pop happens in the same cycle.
- FIFO pointers are log2(DEPTH)+1 bits with natural wrap-around. Full and empty are derived from the MSB/LSB comparison.

## Timing
- Reset values:
  - `cmd_out` = 3'h0
  - `cmd_strobe` = 0
  - `illegal_pulse` = 0
  - `illegal_cnt` = 0
  - `locked` = 0
  - `in_ready` = 1
  - State IDLE, FIFO empty
- Latency: a command accepted on edge E0 appears on `cmd_out` with `cmd_strobe` after edge E1 (1-cycle minimum, IDLE, empty FIFO).
- Throughput: one command per `GAP+1` cycles.
- `cmd_out` is stable between strobes. The downstream FSM samples it every cycle, so the value persists.
- Reset asserted mid-operation: all state and the FIFO clear immediately. Queued commands are lost.

## Structure
- Package `fsm_cmd_pkg` contains:
  - `cmd_t` (logic [2:0])
  - the state enum {IDLE, GAP, LOCKED}
  - `SAFE_CMD` = 3'h0
  - `CMD_MAX_LEGAL` = 3'h5
  - function `is_legal(cmd_t)`
- Sub-module `cmd_fifo`: parameterized DEPTH/width synchronous FIFO with push, pop, full, empty, and flush inputs.
- The top-level module holds the issue FSM, the GAP counter and the illegal counter.

## Test plan
- Reset, then push 3'h4 (GAP=1): `cmd_out`=3'h4 with `cmd_strobe` one cycle after acceptance; the next strobe comes no earlier than 2 cycles later.
- Push 3'h7 once: `cmd_out`=3'h0, `illegal_pulse`=1, `illegal_cnt`=1, `locked`=0.
- Push 3'h6 four times (LOCK_THRESH=4), then 3'h2: `locked`=1 on the 4th illegal strobe; 3'h2 is dropped and `cmd_out` stays 3'h0; after a `clear_lock` pulse, `locked`=0 and `illegal_cnt`=0.
- Hold `in_valid` with the FSM in GAP: after 4 pushes, `in_ready`=0; entries drain in order 3'h1,3'h2,3'h3,3'h5 and pointers wrap correctly over 3+ fills.
- `clear_lock` in the same cycle as the threshold-reaching illegal issue: `locked` stays 0 and `illegal_cnt`=0.
- Assert `rst` with 3 entries queued mid-GAP: all outputs return to reset values within the same cycle; no strobes follow release.
